// File: rtl/tap_table_ctrl_pkg.sv
// Shared types and default sizing for the tap-table controller.
// Table entries are packed as {valid, tap_addr, is_local}.
package tap_table_ctrl_pkg;

  localparam int N_OBJ_DEF         = 4;
  localparam int OBJ_ID_W_DEF      = 2;
  localparam int SAMPLE_ADDR_W_DEF = 10;
  localparam int ID_W_DEF          = 4;
  localparam int DELAY_W_DEF       = 14;
  localparam int SCEN_LEN_W_DEF    = 13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_EMIT = 2'd2
  } state_t;

  function automatic int entry_w(input int addr_w);
    return addr_w + 2;
  endfunction

endpackage

// File: rtl/tap_table_ctrl_bank_calc.sv
// Converts a raw delay into a sample-memory tap address, flags underflow,
// and decides whether the tap lands in this controller's bank.
module tap_bank_calc #(
  parameter int SAMPLE_ADDR_W = 10,
  parameter int ID_W          = 4,
  parameter int DELAY_W       = 14
) (
  input  logic [DELAY_W-1:0]       i_delay,
  input  logic [DELAY_W-1:0]       i_latency,
  input  logic [ID_W-1:0]          i_local_id,
  output logic [SAMPLE_ADDR_W-1:0] o_tap_addr,
  output logic                     o_is_local,
  output logic                     o_underflow
);

  logic [DELAY_W-1:0] w_tap;

  assign w_tap       = i_delay - i_latency;
  assign o_underflow = (i_delay < i_latency);
  assign o_tap_addr  = w_tap[SAMPLE_ADDR_W-1:0];
  // Upper delay bits select the bank that owns the sample.
  assign o_is_local  = (w_tap[DELAY_W-1:SAMPLE_ADDR_W] == i_local_id);

endmodule

// File: rtl/tap_table_ctrl.sv
// Double-buffered tap table with a scenario counter; a pending commit swaps
// tables at the scenario wrap and the new active table is scanned out once.
module tap_table_ctrl
  import tap_table_ctrl_pkg::*;
#(
  parameter int N_OBJ         = N_OBJ_DEF,
  parameter int OBJ_ID_W      = OBJ_ID_W_DEF,
  parameter int SAMPLE_ADDR_W = SAMPLE_ADDR_W_DEF,
  parameter int ID_W          = ID_W_DEF,
  parameter int DELAY_W       = DELAY_W_DEF,
  parameter int SCEN_LEN_W    = SCEN_LEN_W_DEF
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic                              i_start,
  input  logic                              i_entry_valid,
  input  logic [DELAY_W-1:0]                i_delay_in,
  input  logic [OBJ_ID_W-1:0]               i_obj_id_in,
  input  logic [DELAY_W-1:0]                i_hardware_latency,
  input  logic [SCEN_LEN_W-1:0]             i_scenario_len,
  input  logic [ID_W-1:0]                   i_local_id,
  input  logic                              i_commit,
  output logic [SCEN_LEN_W-1:0]             o_scenario_counter,
  output logic                              o_scenario_update,
  output logic [SAMPLE_ADDR_W+OBJ_ID_W-1:0] o_tap_loc_packet,
  output logic                              o_tap_loc_valid,
  output logic                              o_tap_is_local,
  output logic                              o_commit_pending,
  output logic                              o_underflow_err
);

  localparam int ENTRY_W = entry_w(SAMPLE_ADDR_W);

  state_t                  r_state;
  state_t                  w_state_next;
  logic [SCEN_LEN_W-1:0]   r_counter;
  logic [SCEN_LEN_W-1:0]   w_counter_next;
  logic [OBJ_ID_W-1:0]     r_scan_idx;
  logic [OBJ_ID_W-1:0]     w_scan_next;
  logic                    r_active;
  logic                    r_pending;
  logic                    r_underflow;
  logic [ENTRY_W-1:0]      r_tab [2][N_OBJ];

  logic                    w_wrap;
  logic                    w_swap;
  logic                    w_wr_sel;
  logic [SCEN_LEN_W:0]     w_cnt_inc;
  logic [SAMPLE_ADDR_W-1:0] w_tap_addr;
  logic                    w_is_local;
  logic                    w_underflow;
  logic [ENTRY_W-1:0]      w_new_entry;
  logic [ENTRY_W-1:0]      w_cur;
  logic                    w_emit_valid;

  tap_bank_calc #(
    .SAMPLE_ADDR_W (SAMPLE_ADDR_W),
    .ID_W          (ID_W),
    .DELAY_W       (DELAY_W)
  ) u_calc (
    .i_delay     (i_delay_in),
    .i_latency   (i_hardware_latency),
    .i_local_id  (i_local_id),
    .o_tap_addr  (w_tap_addr),
    .o_is_local  (w_is_local),
    .o_underflow (w_underflow)
  );

  assign w_new_entry = {~w_underflow, w_tap_addr, w_is_local};
  assign w_cnt_inc   = {1'b0, r_counter} + {{SCEN_LEN_W{1'b0}}, 1'b1};

  always_comb begin
    w_state_next   = r_state;
    w_counter_next = r_counter;
    w_scan_next    = r_scan_idx;
    w_wrap         = 1'b0;
    w_swap         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) w_state_next = ST_RUN;
      end
      ST_RUN, ST_EMIT: begin
        // counter+1 >= len also covers len of 0 and 1 (wrap every cycle).
        w_wrap         = (w_cnt_inc >= {1'b0, i_scenario_len});
        w_counter_next = w_wrap ? '0 : w_cnt_inc[SCEN_LEN_W-1:0];
        if (r_state == ST_EMIT) begin
          w_scan_next = r_scan_idx + OBJ_ID_W'(1);
          if (r_scan_idx == OBJ_ID_W'(N_OBJ - 1)) w_state_next = ST_RUN;
        end
        if (w_wrap && r_pending) begin
          w_swap       = 1'b1;
          w_state_next = ST_EMIT;
          w_scan_next  = '0;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_counter   <= '0;
      r_scan_idx  <= '0;
      r_active    <= 1'b0;
      r_pending   <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_counter  <= w_counter_next;
      r_scan_idx <= w_scan_next;
      r_active   <= r_active ^ w_swap;
      // A commit arriving in the swap cycle stays pending for the next wrap.
      r_pending  <= i_commit | (r_pending & ~w_swap);
      if (i_entry_valid && w_underflow) r_underflow <= 1'b1;
    end
  end

  // In the swap cycle the old active table becomes the shadow being written.
  assign w_wr_sel = w_swap ? r_active : ~r_active;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int t = 0; t < 2; t++) begin
        for (int e = 0; e < N_OBJ; e++) begin
          r_tab[t][e] <= '0;
        end
      end
    end else begin
      for (int t = 0; t < 2; t++) begin
        for (int e = 0; e < N_OBJ; e++) begin
          if (w_swap && (r_active == 1'(t))) r_tab[t][e][ENTRY_W-1] <= 1'b0;
          if (i_entry_valid && (w_wr_sel == 1'(t)) && (i_obj_id_in == OBJ_ID_W'(e)))
            r_tab[t][e] <= w_new_entry;
        end
      end
    end
  end

  assign w_cur        = r_tab[r_active][r_scan_idx];
  assign w_emit_valid = (r_state == ST_EMIT) && w_cur[ENTRY_W-1];

  assign o_scenario_counter = r_counter;
  assign o_scenario_update  = w_wrap;
  assign o_tap_loc_valid    = w_emit_valid;
  assign o_tap_loc_packet   = w_emit_valid ? {w_cur[ENTRY_W-2:1], r_scan_idx} : '0;
  assign o_tap_is_local     = w_emit_valid & w_cur[0];
  assign o_commit_pending   = r_pending;
  assign o_underflow_err    = r_underflow;

endmodule

// File: doc/tap_table_ctrl.md
TAP_TABLE_CTRL -- requirements
Module: tap_table_ctrl

Parameters
REQ-001 N_OBJ, default 4: number of tracked objects (power of two, 2..64).
REQ-002 OBJ_ID_W, default 2: log2(N_OBJ).
REQ-003 SAMPLE_ADDR_W, default 10: sample-memory address width (N_SAMPLE = 2^SAMPLE_ADDR_W).
REQ-004 ID_W, default 4: local-controller id width.
REQ-005 DELAY_W, default 14: delay width; SHALL equal SAMPLE_ADDR_W + ID_W.
REQ-006 SCEN_LEN_W, default 13: scenario counter width.

Interface
REQ-007 CLK  in  1  system clock; all state on rising edge.
REQ-008 reset  in  1  asynchronous, active-low reset.
REQ-009 start  in  1  one-cycle pulse; starts the scenario counter.
REQ-010 entry_valid  in  1  delay_in/obj_id_in valid this cycle.
REQ-011 delay_in  in  DELAY_W  raw delay-matrix element.
REQ-012 obj_id_in  in  OBJ_ID_W  target object.
REQ-013 hardware_latency  in  DELAY_W  quasi-static latency subtracted from each delay.
REQ-014 scenario_len  in  SCEN_LEN_W  scenario period in cycles.
REQ-015 local_id  in  ID_W  this controller's bank id.
REQ-016 commit  in  1  one-cycle pulse; request shadow-to-active swap.
REQ-017 scenario_counter  out  SCEN_LEN_W  current cycle within scenario.
REQ-018 scenario_update  out  1  one-cycle pulse at counter wrap.
REQ-019 tap_loc_packet  out  SAMPLE_ADDR_W+OBJ_ID_W  {tap_addr, obj_id}.
REQ-020 tap_loc_valid  out  1  tap_loc_packet valid.
REQ-021 tap_is_local  out  1  emitted tap resides in local bank.
REQ-022 commit_pending  out  1  swap requested, not yet taken.
REQ-023 underflow_err  out  1  sticky: some delay_in < hardware_latency.

Function
REQ-024 Two tables (A/B) of N_OBJ entries {valid, tap_addr, is_local}; one active, one shadow; A active after reset.
REQ-025 On entry_valid: tap = delay_in - hardware_latency; shadow[obj_id_in] <= {1, tap[SAMPLE_ADDR_W-1:0], tap[DELAY_W-1:SAMPLE_ADDR_W]==local_id}; written next edge.
REQ-026 If delay_in < hardware_latency: shadow[obj_id_in].valid <= 0, underflow_err <= 1 (cleared only by reset).
REQ-027 Repeated writes to the same obj_id: last write wins.
REQ-028 FSM states IDLE, RUN, EMIT; IDLE->RUN on start; start outside IDLE ignored.
REQ-029 In RUN/EMIT counter increments each cycle; at counter >= scenario_len-1 it wraps to 0 and scenario_update pulses that cycle; scenario_len 0 or 1 -> pulse every cycle.
REQ-030 commit sets commit_pending; at a wrap with commit_pending=1 (set before that cycle): swap active/shadow, clear pending, clear new shadow valid bits, go to EMIT.
REQ-031 commit coinciding with a wrap is held pending to the next wrap.
REQ-032 entry_valid in the swap cycle writes the new shadow after the clear (write survives).
REQ-033 EMIT scans active indices 0..N_OBJ-1, one per cycle starting the cycle after swap; valid entries drive tap_loc_valid=1 with packet/is_local; invalid entries drive tap_loc_valid=0; after index N_OBJ-1 -> RUN.
REQ-034 A wrap during EMIT with commit_pending restarts the scan from index 0 on the newly swapped table.
REQ-035 Counter continues through EMIT; tap_loc_valid is 0 outside EMIT.

Reset
REQ-036 On reset low: FSM IDLE, counter 0, all valid bits 0, A active, outputs scenario_update/tap_loc_valid/tap_is_local/commit_pending/underflow_err 0, tap_loc_packet 0; takes effect immediately, including mid-EMIT.

Structure
REQ-037 Shared package holds the FSM state enum, default parameter values and the table-entry struct width.
REQ-038 One sub-module, tap_bank_calc: combinational subtract, underflow flag, bank compare.

Verification (SAMPLE_ADDR_W=10, local_id=0, hardware_latency=0, scenario_len=32)
REQ-039 Write (50,obj1),(10000,obj0),(12000,obj2), commit, start -> at first wrap, EMIT emits obj0 addr 784 local=0, obj1 addr 50 local=1, obj2 addr 736 local=0; obj3 tap_loc_valid=0.
REQ-040 hardware_latency=100, delay 50 -> underflow_err=1, entry invalid, no packet emitted for it.
REQ-041 commit asserted in wrap cycle -> no swap that wrap; swap and EMIT at the following wrap (32 cycles later).
REQ-042 scenario_len=1 -> scenario_update high every cycle; counter stays 0.
REQ-043 Reset asserted mid-EMIT -> all outputs 0 immediately; after release, start required to restart the counter.
